// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences a single-ported RAM between the instruction fetch
// path and the data path. One RAM access is in flight at a time. Data has
// priority over fetch, limited by a streak counter so a pending fetch is
// never starved. Stalled accesses are aborted by a timeout (sticky err),
// and a halt request parks the memory system once it is idle.
module mem_arbiter #(
  parameter int WORD_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  input  logic              halt,
  input  logic              ram_ready,
  input  logic [WORD_W-1:0] ramload,
  output logic              iwait,
  output logic              dwait,
  output logic [WORD_W-1:0] iload,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  output logic              err,
  output logic              halted
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_DSTREAK + 1);

  // The abort decision is taken on the last stalled cycle, so the timer
  // register reaches TIMEOUT on the same edge that drops the strobes.
  localparam logic [TW-1:0] timer_last_c = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] timer_one_c  = TW'(1);
  localparam logic [SW-1:0] streak_max_c = SW'(MAX_DSTREAK);
  localparam logic [SW-1:0] streak_one_c = SW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DACC   = 2'd1,
    IACC   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t              state_r;
  logic [TW-1:0]       timer_r;
  logic [SW-1:0]       streak_r;
  logic                ramren_r;
  logic                ramwen_r;
  logic [WORD_W-1:0]   ramaddr_r;
  logic [WORD_W-1:0]   ramstore_r;
  logic                err_r;
  logic                halted_r;

  logic                dreq_s;
  logic                dgrant_s;
  logic                ddone_s;
  logic                idone_s;

  // Request decode, data-grant eligibility and same-cycle completion detect.
  always_comb begin
    dreq_s   = dREN | dWEN;
    dgrant_s = dreq_s & ~(iREN & (streak_r == streak_max_c));
    ddone_s  = (state_r == DACC) & ram_ready;
    idone_s  = (state_r == IACC) & ram_ready;
  end

  assign iwait    = iREN & ~idone_s;
  assign dwait    = dreq_s & ~ddone_s;
  assign iload    = ramload;
  assign dload    = ramload;
  assign ramREN   = ramren_r;
  assign ramWEN   = ramwen_r;
  assign ramaddr  = ramaddr_r;
  assign ramstore = ramstore_r;
  assign err      = err_r;
  assign halted   = halted_r;

  // Arbitration, access sequencing, streak tracking, timeout and halt parking.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r    <= IDLE;
      timer_r    <= {TW{1'b0}};
      streak_r   <= {SW{1'b0}};
      ramren_r   <= 1'b0;
      ramwen_r   <= 1'b0;
      ramaddr_r  <= {WORD_W{1'b0}};
      ramstore_r <= {WORD_W{1'b0}};
      err_r      <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (dgrant_s) begin
            // A combined read+write request is carried out as a write.
            state_r    <= DACC;
            ramaddr_r  <= daddr;
            ramstore_r <= dstore;
            ramwen_r   <= dWEN;
            ramren_r   <= dREN & ~dWEN;
            timer_r    <= {TW{1'b0}};
          end else if (iREN) begin
            state_r   <= IACC;
            ramaddr_r <= iaddr;
            ramren_r  <= 1'b1;
            ramwen_r  <= 1'b0;
            timer_r   <= {TW{1'b0}};
          end else if (halt) begin
            state_r  <= HALTED;
            halted_r <= 1'b1;
            ramren_r <= 1'b0;
            ramwen_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        DACC, IACC: begin
          if (ram_ready) begin
            state_r  <= IDLE;
            ramren_r <= 1'b0;
            ramwen_r <= 1'b0;
            if ((state_r == DACC) && iREN) begin
              if (streak_r != streak_max_c) begin
                streak_r <= streak_r + streak_one_c;
              end else begin
                streak_r <= streak_r;
              end
            end else begin
              streak_r <= {SW{1'b0}};
            end
          end else if (timer_r == timer_last_c) begin
            // Abort: the requester's wait stays high so it retries.
            state_r  <= IDLE;
            ramren_r <= 1'b0;
            ramwen_r <= 1'b0;
            err_r    <= 1'b1;
            timer_r  <= timer_r + timer_one_c;
          end else begin
            timer_r <= timer_r + timer_one_c;
          end
        end
        HALTED: begin
          state_r  <= HALTED;
          halted_r <= 1'b1;
          ramren_r <= 1'b0;
          ramwen_r <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          ramren_r <= 1'b0;
          ramwen_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_mem_arbiter;

  localparam int W    = 32;
  localparam int MAXD = 4;
  localparam int TMO  = 255;

  logic          CLK;
  logic          nRST;
  logic          iREN, dREN, dWEN, halt, ram_ready;
  logic [W-1:0]  iaddr, daddr, dstore, ramload;
  logic          iwait, dwait, ramREN, ramWEN, err, halted;
  logic [W-1:0]  iload, dload, ramaddr, ramstore;

  mem_arbiter #(.WORD_W(W), .MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN),
    .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .halt(halt),
    .ram_ready(ram_ready), .ramload(ramload), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .err(err), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0; ram_ready = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h0;
  endtask

  // ---------------- behavioural reference model ----------------
  // owner: 0 nobody, 1 data path, 2 fetch path, 3 parked
  int          m_owner, m_cycles, m_streak;
  bit          m_err, m_ren, m_wen;
  logic [31:0] m_addr, m_store;

  task automatic model_reset();
    m_owner = 0; m_cycles = 0; m_streak = 0; m_err = 1'b0;
    m_ren = 1'b0; m_wen = 1'b0; m_addr = 32'h0; m_store = 32'h0;
  endtask

  task automatic model_step();
    case (m_owner)
      0: begin
        if ((dREN || dWEN) && !(iREN && m_streak == MAXD)) begin
          m_owner = 1; m_addr = daddr; m_store = dstore;
          m_wen = dWEN; m_ren = !dWEN; m_cycles = 0;
        end else if (iREN) begin
          m_owner = 2; m_addr = iaddr; m_ren = 1'b1; m_wen = 1'b0; m_cycles = 0;
        end else if (halt) begin
          m_owner = 3;
        end
      end
      1, 2: begin
        if (ram_ready) begin
          if (m_owner == 1 && iREN) m_streak = (m_streak < MAXD) ? m_streak + 1 : MAXD;
          else m_streak = 0;
          m_owner = 0; m_ren = 1'b0; m_wen = 1'b0;
        end else begin
          m_cycles++;
          if (m_cycles >= TMO) begin
            m_err = 1'b1; m_owner = 0; m_ren = 1'b0; m_wen = 1'b0;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    idle_inputs();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        i, dr, dw;
    logic [31:0] ia, da, ds, load;
    int          rdy;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic        dside;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input int idx);
    logic w;
    @(negedge CLK);
    iREN = v.i; dREN = v.dr; dWEN = v.dw;
    iaddr = v.ia; daddr = v.da; dstore = v.ds; ramload = v.load; ram_ready = 1'b0;
    #1;
    w = v.dside ? dwait : iwait;
    check($sformatf("vec%0d_wait_arb", idx), w, 1'b1);
    for (int k = 1; k <= v.rdy; k++) begin
      @(negedge CLK);
      ram_ready = (k == v.rdy);
      #1;
      check($sformatf("vec%0d_ramREN_c%0d", idx, k), ramREN, v.e_ren);
      check($sformatf("vec%0d_ramWEN_c%0d", idx, k), ramWEN, v.e_wen);
      check($sformatf("vec%0d_ramaddr_c%0d", idx, k), ramaddr, v.e_addr);
      if (v.e_wen) check($sformatf("vec%0d_ramstore", idx), ramstore, v.e_store);
      w = v.dside ? dwait : iwait;
      check($sformatf("vec%0d_wait_c%0d", idx, k), w, (k == v.rdy) ? 1'b0 : 1'b1);
      if (k == v.rdy) check($sformatf("vec%0d_load", idx), v.dside ? dload : iload, v.load);
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    check($sformatf("vec%0d_ren_drop", idx), ramREN, 1'b0);
    check($sformatf("vec%0d_wen_drop", idx), ramWEN, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int grants[10];
    int ng;
    logic ic_prev, dc_prev;

    nRST = 1'b0;
    idle_inputs();
    model_reset();
    do_reset();

    // reset state
    #1;
    check("rst_ramREN", ramREN, 1'b0);
    check("rst_ramWEN", ramWEN, 1'b0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);
    check("rst_err", err, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_iwait", iwait, 1'b0);
    check("rst_dwait", dwait, 1'b0);

    // table: fetch, data read (min latency), write, read+write, fetch+data
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h11112222, 3, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 32'hA5A50001, 1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h40, 32'hDEADBEEF, 32'h0, 2, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h44, 32'h12345678, 32'h0, 1, 1'b0, 1'b1, 32'h44, 32'h12345678, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h104, 32'h200, 32'h0, 32'h0BADF00D, 2, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1};
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // simultaneous fetch and data: data first, then fetch
    do_reset();
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'h104; dREN = 1'b1; daddr = 32'h200; ramload = 32'h00C0FFEE;
    @(negedge CLK);
    ram_ready = 1'b1;
    #1;
    check("both_first_addr", ramaddr, 32'h200);
    check("both_dwait_done", dwait, 1'b0);
    check("both_iwait_held", iwait, 1'b1);
    @(negedge CLK);
    dREN = 1'b0; ram_ready = 1'b0;
    #1;
    check("both_idle_ren", ramREN, 1'b0);
    @(negedge CLK);
    ram_ready = 1'b1;
    #1;
    check("both_second_ren", ramREN, 1'b1);
    check("both_second_addr", ramaddr, 32'h104);
    check("both_iwait_done", iwait, 1'b0);
    @(negedge CLK);
    idle_inputs();

    // anti-starvation: iREN held, back-to-back writes, RAM always ready
    do_reset();
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'h500; dWEN = 1'b1; daddr = 32'h600; ram_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      @(negedge CLK);
      #1;
      if (ramWEN) begin grants[ng] = 0; ng++; end
      else if (ramREN && ramaddr == 32'h500) begin grants[ng] = 1; ng++; end
    end
    check("streak_grant_count", ng, 10);
    for (int g = 0; g < ng; g++)
      check($sformatf("streak_grant%0d_is_fetch", g), grants[g], (g == 4 || g == 9) ? 1 : 0);
    @(negedge CLK);
    idle_inputs();

    // timeout: data read never acknowledged
    do_reset();
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h300;
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      #1;
      if (ramREN) cnt++;
      else if (cnt > 0) break;
    end
    check("tmo_strobe_cycles", cnt, TMO);
    check("tmo_err", err, 1'b1);
    check("tmo_dwait_held", dwait, 1'b1);
    check("tmo_ren_dropped", ramREN, 1'b0);
    @(negedge CLK);
    #1;
    check("tmo_retry_ren", ramREN, 1'b1);
    check("tmo_retry_addr", ramaddr, 32'h300);
    ram_ready = 1'b1;
    #1;
    check("tmo_retry_done", dwait, 1'b0);
    @(negedge CLK);
    dREN = 1'b0; ram_ready = 1'b0;
    #1;
    check("tmo_err_sticky", err, 1'b1);

    // asynchronous reset in the middle of a data write
    @(negedge CLK);
    dWEN = 1'b1; daddr = 32'h40;
    @(negedge CLK);
    #1;
    check("arst_pre_wen", ramWEN, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    check("arst_wen", ramWEN, 1'b0);
    check("arst_ramaddr", ramaddr, 32'h0);
    check("arst_err", err, 1'b0);
    check("arst_halted", halted, 1'b0);
    @(negedge CLK);
    idle_inputs();
    nRST = 1'b1;

    // randomized run against the model
    do_reset();
    ic_prev = 1'b0; dc_prev = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic ei, ed;
      int kind;
      @(negedge CLK);
      if (ic_prev) iREN = 1'b0;
      if (dc_prev) begin dREN = 1'b0; dWEN = 1'b0; end
      if (!iREN && ($urandom % 4 == 0)) begin
        iREN = 1'b1; iaddr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dREN && !dWEN && ($urandom % 3 == 0)) begin
        kind = $urandom % 3;
        dREN = (kind != 1); dWEN = (kind != 0);
        daddr = $urandom & 32'hFFFF_FFFC; dstore = $urandom;
      end
      ram_ready = ($urandom % 3 == 0);
      ramload = $urandom;
      #1;
      ei = iREN && !(m_owner == 2 && ram_ready);
      ed = (dREN || dWEN) && !(m_owner == 1 && ram_ready);
      check("rnd_iwait", iwait, ei);
      check("rnd_dwait", dwait, ed);
      check("rnd_ramREN", ramREN, m_ren);
      check("rnd_ramWEN", ramWEN, m_wen);
      check("rnd_ramaddr", ramaddr, m_addr);
      check("rnd_ramstore", ramstore, m_store);
      check("rnd_err", err, m_err);
      check("rnd_halted", halted, m_owner == 3);
      check("rnd_dload", dload, ramload);
      ic_prev = iREN && !ei;
      dc_prev = (dREN || dWEN) && !ed;
      model_step();
    end

    // halt raised during a fetch: fetch completes, then park
    do_reset();
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'h700; ramload = 32'h5EED5EED;
    @(negedge CLK);
    halt = 1'b1;
    #1;
    check("halt_fetch_ren", ramREN, 1'b1);
    @(negedge CLK);
    ram_ready = 1'b1;
    #1;
    check("halt_fetch_done", iwait, 1'b0);
    check("halt_fetch_iload", iload, 32'h5EED5EED);
    check("halt_not_yet", halted, 1'b0);
    @(negedge CLK);
    iREN = 1'b0; ram_ready = 1'b0;
    #1;
    check("halt_idle_halted", halted, 1'b0);
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h800;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("halt_halted", halted, 1'b1);
      check("halt_ren", ramREN, 1'b0);
      check("halt_wen", ramWEN, 1'b0);
      check("halt_dwait", dwait, 1'b1);
      @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
